// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, colour types and
// the colour-bar helpers used by the optional test pattern
// (enabled with VGA_TIMING_TESTPAT_EN).
package vga_pkg;

    localparam int CLK_DIV_DEF   = 4;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bar index 0..7 for column h, bars of width bar_w starting at column 0.
    function automatic logic [2:0] bar_sel(input logic [9:0] h, input logic [9:0] bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= 10'(i) * bar_w) idx = 3'(i);
        end
        return idx;
    endfunction

    // Bar index bits map straight onto full-scale R, G, B.
    function automatic rgb12_t bar_color(input logic [2:0] idx);
        return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Clock-enable divider: one-clk tick every DIV system clocks (DIV >= 2).
module vga_tick_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // Free-running modulo-DIV counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              div_cnt <= '0;
        else if (div_cnt == LAST) div_cnt <= '0;
        else                     div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scan timing: pixel tick, h/v counters, renderer coordinates and
// registered RGB444 + sync pins lagging the coordinates by one pixel.
// Optional colour-bar test pattern under VGA_TIMING_TESTPAT_EN.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_TIMING_TESTPAT_EN
    input  logic        test_mode,
`endif
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_valid,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       in_hs;
    logic       in_vs;
    rgb12_t     src;
    rgb444_t    pin_q;

    vga_tick_div #(.DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Raster position; v steps once per completed line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign pix_valid = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign pix_x     = pix_valid ? h_cnt : '0;
    assign pix_y     = pix_valid ? v_cnt[8:0] : '0;

    assign in_hs = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign in_vs = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef VGA_TIMING_TESTPAT_EN
    assign src = test_mode ? bar_color(bar_sel(h_cnt, 10'(H_VISIBLE / 8))) : rgb_in;
`else
    assign src = rgb_in;
`endif

    // Pin stage: colour and sync captured together on the tick so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_q  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else if (tick) begin
            pin_q  <= pix_valid ? rgb444_t'(src) : '0;
            vga_hs <= !in_hs;
            vga_vs <= !in_vs;
        end
    end

    // Pulse on the clk after the raster wraps from the last pixel to (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_start <= 1'b0;
        else        frame_start <= tick && h_wrap && v_wrap;
    end

    assign vga_r = pin_q.r;
    assign vga_g = pin_q.g;
    assign vga_b = pin_q.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: default horizontal timing, shortened vertical
// timing (8 lines per frame) so whole frames fit in a short run.
module tb_vga_timing_ctrl;

    localparam int D  = 4;
    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 4,   VF = 1,  VS = 2,  VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        test_mode = 0;
    logic [11:0] rgb_in = 0;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_valid;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;

    vga_timing_ctrl #(
        .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef VGA_TIMING_TESTPAT_EN
        .test_mode(test_mode),
`endif
        .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int k;
    logic [11:0] smp;
    logic chk_en = 0;
    logic rgb_rand = 0;

    // Clocks since reset release, plus the colour present at each pixel tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= 0;
            smp <= 0;
        end else begin
            k <= k + 1;
            if ((k + 1) % D == 0) smp <= rgb_in;
        end
    end

    // Renderer: coordinate-derived colour, or noise to check sampling instant.
    always @(negedge clk)
        rgb_in = rgb_rand ? 12'($urandom) : {pix_x[3:0], pix_y[3:0], 4'hA};

    function automatic logic [34:0] pk(input int px, input int py, input logic pv,
                                       input logic [11:0] c, input logic hs, input logic vs,
                                       input logic fs);
        return {10'(px), 9'(py), pv, c, hs, vs, fs};
    endfunction

    function automatic logic [34:0] act_vec();
        return {pix_x, pix_y, pix_valid, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start};
    endfunction

    // Reference: pixel index = clocks / D; pins show the previous pixel.
    function automatic logic [34:0] model(input int kk, input logic [11:0] s, input logic tm);
        int p, h, v, q, hq, vq;
        logic pv, vis, hs, vs, fs;
        logic [11:0] c;
        logic [2:0] idx;
        p  = kk / D;
        h  = p % HT;
        v  = (p / HT) % VT;
        pv = (h < HV) && (v < VV);
        c = 0; hs = 1; vs = 1;
        if (p > 0) begin
            q   = p - 1;
            hq  = q % HT;
            vq  = (q / HT) % VT;
            vis = (hq < HV) && (vq < VV);
            idx = 3'(hq / (HV / 8));
            if (vis) c = tm ? {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}} : s;
            hs = !(hq >= HV + HF && hq < HV + HF + HS);
            vs = !(vq >= VV + VF && vq < VV + VF + VS);
        end
        fs = (kk % D == 0) && (p > 0) && (p % (HT * VT) == 0);
        return pk(pv ? h : 0, pv ? v : 0, pv, c, hs, vs, fs);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d act=%0h exp=%0h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk)
        if (chk_en) chk("model", 64'(act_vec()), 64'(model(k, smp, test_mode)));

    // Monitor for sync widths and frame_start cadence.
    logic mon_en = 0;
    logic hs_prev = 1, vs_prev = 1, fs_prev = 0;
    int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    int fs_n = 0, fs_hi = 0;
    int fs_k[4];
    always @(negedge clk) begin
        if (mon_en) begin
            if (hs_prev && !vga_hs && hs_fall < 0) hs_fall = k;
            if (!hs_prev && vga_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
            if (vs_prev && !vga_vs && vs_fall < 0) vs_fall = k;
            if (!vs_prev && vga_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = k;
            if (frame_start) begin
                fs_hi++;
                if (!fs_prev) begin
                    if (fs_n < 4) fs_k[fs_n] = k;
                    fs_n++;
                end
            end
        end
        hs_prev = vga_hs; vs_prev = vga_vs; fs_prev = frame_start;
    end

    task automatic wait_k(input int target);
        int guard = 0;
        while (k < target && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_k", 64'(k >= target), 64'(1));
    endtask

    typedef struct {
        int          k;
        logic [34:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{3,     pk(0, 0, 1, 12'h000, 1, 1, 0)};
        tbl[1]  = '{4,     pk(1, 0, 1, 12'h00A, 1, 1, 0)};
        tbl[2]  = '{24,    pk(6, 0, 1, 12'h50A, 1, 1, 0)};
        tbl[3]  = '{2560,  pk(0, 0, 0, 12'hF0A, 1, 1, 0)};
        tbl[4]  = '{2564,  pk(0, 0, 0, 12'h000, 1, 1, 0)};
        tbl[5]  = '{2627,  pk(0, 0, 0, 12'h000, 1, 1, 0)};
        tbl[6]  = '{2628,  pk(0, 0, 0, 12'h000, 0, 1, 0)};
        tbl[7]  = '{3011,  pk(0, 0, 0, 12'h000, 0, 1, 0)};
        tbl[8]  = '{3012,  pk(0, 0, 0, 12'h000, 1, 1, 0)};
        tbl[9]  = '{3200,  pk(0, 1, 1, 12'h000, 1, 1, 0)};
        tbl[10] = '{9620,  pk(5, 3, 1, 12'h43A, 1, 1, 0)};
        tbl[11] = '{9624,  pk(6, 3, 1, 12'h53A, 1, 1, 0)};
        tbl[12] = '{16003, pk(0, 0, 0, 12'h000, 1, 1, 0)};
        tbl[13] = '{16004, pk(0, 0, 0, 12'h000, 1, 0, 0)};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_vals", 64'(act_vec()), 64'(pk(0, 0, 1, 0, 1, 1, 0)));
        @(negedge clk);
        rst_n  = 1;
        mon_en = 1;

        // Directed timing vectors with the coordinate renderer.
        foreach (tbl[i]) begin
            wait_k(tbl[i].k);
            chk($sformatf("vec%0d", i), 64'(act_vec()), 64'(tbl[i].exp));
        end

        // Random colour stream against the reference model over two frames.
        rgb_rand = 1;
        chk_en   = 1;
        wait_k(52000);
        chk_en = 0;

        chk("hs_fall_k",  64'(hs_fall), 64'(656 * D + D));
        chk("hs_low_len", 64'(hs_rise - hs_fall), 64'(HS * D));
        chk("vs_fall_k",  64'(vs_fall), 64'((HT * (VV + VF) + 1) * D));
        chk("vs_low_len", 64'(vs_rise - vs_fall), 64'(VS * HT * D));
        chk("fs_count",   64'(fs_n), 64'(2));
        chk("fs_width",   64'(fs_hi), 64'(2));
        chk("fs_first",   64'(fs_k[0]), 64'(HT * VT * D));
        chk("fs_period",  64'(fs_k[1] - fs_k[0]), 64'(HT * VT * D));

        // Mid-frame asynchronous reset at h=300, v=2 of the third frame.
        chk_en = 1;
        wait_k(2 * HT * VT * D + (2 * HT + 300) * D);
        chk_en = 0;
        chk("pre_rst_pos", 64'({pix_x, pix_y}), 64'({10'd300, 9'd2}));
        #2 rst_n = 0;
        #1 chk("async_rst", 64'(act_vec()), 64'(pk(0, 0, 1, 0, 1, 1, 0)));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold", 64'(act_vec()), 64'(pk(0, 0, 1, 0, 1, 1, 0)));
        fs_n  = 0;
        fs_hi = 0;
        rst_n = 1;
        chk_en = 1;
        wait_k(4000);
        chk_en = 0;
        chk("no_fs_after_rst", 64'(fs_hi), 64'(0));

`ifdef VGA_TIMING_TESTPAT_EN
        // Colour bars with noisy renderer input.
        rst_n = 0;
        test_mode = 1;
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        wait_k(4);
        chk("bar_x0",   64'({vga_r, vga_g, vga_b}), 64'(12'h000));
        wait_k(404);
        chk("bar_x100", 64'({vga_r, vga_g, vga_b}), 64'(12'h00F));
        wait_k(2560);
        chk("bar_x639", 64'({vga_r, vga_g, vga_b}), 64'(12'hFFF));
        chk_en = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
